mc_mem_responder: RTL and testbench

//   Word-organised unified instruction/data memory for the multicycle MIPS datapath.

---
 rtl/mc_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mc_mem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_responder.sv
// mc_mem_responder
//   Word-organised unified instruction/data memory for the multicycle MIPS
//   datapath. One port serves both instruction fetch and data access. A
//   request is accepted in IDLE, held for WAIT_CYCLES wait states, and
//   answered with a one-cycle ready pulse.
//
//   Optional feature macro: MEM_MISALIGN_CHK_EN
//     defined   : addr[1:0] != 0 at accept completes with err=1, rdata=0, no write
//     undefined : addr[1:0] ignored (word aligned down), err tied to 0
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   mem_read   in   1        read request, held until ready
//   mem_write  in   1        write request, held until ready (wins over mem_read)
//   addr       in   ADDR_W   byte address
//   wdata      in   DATA_W   write data
//   rdata      out  DATA_W   read data, nonzero only in the RESP cycle of a read
//   ready      out  1        one-cycle response pulse
//   busy       out  1        request in flight (WAIT or RESP)
//   err        out  1        misaligned access, valid with ready
//
// State | Meaning
// IDLE  | waiting for mem_read/mem_write
// WAIT  | counting wait states, cnt = 0..WAIT_CYCLES-1
// RESP  | ready pulse; write committed on the edge leaving this state

module mc_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              accept;

    // Latched request. lat_word is the zero-extended word index.
    logic [ADDR_W-1:0] lat_word;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_write;
    logic              lat_mis;

    // Operation currently being served: live inputs in IDLE, latched otherwise.
    // Needed because with WAIT_CYCLES=0 the read data is registered on the
    // accept edge itself, before the latch holds anything.
    logic [ADDR_W-1:0] op_word;
    logic              op_write;
    logic              op_mis;
    logic              op_in_range;
    logic              op_ok;
    logic              addr_mis;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

`ifdef MEM_MISALIGN_CHK_EN
    assign addr_mis = |addr[1:0];
    assign err      = (state == S_RESP) && lat_mis;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];
    assign addr_mis        = 1'b0;
    assign err             = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        op_word   = lat_word;
        op_write  = lat_write;
        op_mis    = lat_mis;
        case (state)
            S_IDLE: begin
                op_word  = {2'b00, addr[ADDR_W-1:2]};
                op_write = mem_write;
                op_mis   = addr_mis;
                cnt_nxt  = '0;
                if (mem_read | mem_write) begin
                    accept    = 1'b1;
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign op_in_range = op_word < ADDR_W'(DEPTH_WORDS);
    assign op_ok       = op_in_range && !op_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata     <= '0;
            lat_word  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_mis   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_word  <= op_word;
                lat_wdata <= wdata;
                lat_write <= mem_write;
                lat_mis   <= addr_mis;
            end
            if ((state_nxt == S_RESP) && !op_write && op_ok) begin
                rdata <= mem[op_word[MEM_AW-1:0]];
            end else begin
                rdata <= '0;
            end
        end
    end

    // Array is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_RESP) && lat_write && op_ok) begin
            mem[lat_word[MEM_AW-1:0]] <= lat_wdata;
        end
    end

    assign ready = (state == S_RESP);
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Testbench for mc_mem_responder: two instances (WAIT_CYCLES=2 and 0).
// Stimulus pushes expected responses into a scoreboard queue; a negedge
// monitor pops and compares whenever an instance raises ready.

module tb_mc_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd  [2];
    logic        wr  [2];
    logic [31:0] a   [2];
    logic [31:0] wd  [2];
    logic [31:0] rdv [2];
    logic        rdy [2];
    logic        bsy [2];
    logic        er  [2];

    always #5 clk = ~clk;

    mc_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .addr(a[0]),
        .wdata(wd[0]), .rdata(rdv[0]), .ready(rdy[0]), .busy(bsy[0]), .err(er[0])
    );

    mc_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .addr(a[1]),
        .wdata(wd[1]), .rdata(rdv[1]), .ready(rdy[1]), .busy(bsy[1]), .err(er[1])
    );

    typedef struct {
        int          dev;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdy[d] === 1'b1) begin
                if (sb.size() == 0 || sb[0].dev != d) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_ready dev%0d: got ready=1 expected no response", d);
                end else begin
                    mon_e = sb.pop_front();
                    check32({mon_e.name, "_rdata"}, rdv[d], mon_e.rdata);
                    check1({mon_e.name, "_err"}, er[d], mon_e.err);
                    check32({mon_e.name, "_latency"}, cyc, mon_e.cyc);
                end
            end
        end
    end

    // Issue one request; lat is the instance's WAIT_CYCLES.
    task automatic req(input int d, input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] dat, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input string nm);
        exp_t e;
        bit   seen = 1'b0;
        @(negedge clk);
        rd[d] = r;
        wr[d] = w;
        a[d]  = ad;
        wd[d] = dat;
        @(posedge clk);
        #1;
        e.dev   = d;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + lat;
        e.name  = nm;
        sb.push_back(e);
        check1({nm, "_busy"}, bsy[d], 1'b1);
        // Only the latched address/data may be used from here on.
        a[d]  = ~ad;
        wd[d] = ~dat;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", nm);
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        @(posedge clk);
        #1;
        check1({nm, "_idle_busy"}, bsy[d], 1'b0);
        check1({nm, "_idle_ready"}, rdy[d], 1'b0);
        check32({nm, "_idle_rdata"}, rdv[d], 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            a[d]  = '0;
            wd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check32("reset_rdata", rdv[d], 32'h0);
            check1("reset_ready", rdy[d], 1'b0);
            check1("reset_busy", bsy[d], 1'b0);
            check1("reset_err", er[d], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // WAIT_CYCLES=2 instance
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "wr_10");
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "rd_10");
        req(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 2, "both_20");
        req(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 2, "rd_20");
        req(0, 1'b0, 1'b1, 32'h0, 32'hA5A50000, 32'h0, 1'b0, 2, "wr_0");
        req(0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b0, 2, "wr_oor");
        req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b0, 2, "rd_oor");
        req(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A50000, 1'b0, 2, "rd_0_after_oor");
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "rd_10_after_oor");
        req(0, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, 2, "wr_40");

        // Reset during WAIT of a write to 0x40
        @(negedge clk);
        wr[0] = 1'b1;
        a[0]  = 32'h40;
        wd[0] = 32'h11111111;
        @(posedge clk);
        #1;
        check1("abort_busy_wait", bsy[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check1("abort_busy_after_rst", bsy[0], 1'b0);
        check1("abort_ready_after_rst", rdy[0], 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        wr[0] = 1'b0;
        repeat (4) @(posedge clk);
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 2, "rd_40_after_abort");

`ifdef MEM_MISALIGN_CHK_EN
        req(0, 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 2, "rd_mis_13");
        req(0, 1'b0, 1'b1, 32'h11, 32'h22222222, 32'h0, 1'b1, 2, "wr_mis_11");
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "rd_10_after_mis");
`else
        req(0, 1'b1, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 2, "rd_mis_13");
        req(0, 1'b0, 1'b1, 32'h11, 32'h22222222, 32'h0, 1'b0, 2, "wr_mis_11");
        req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h22222222, 1'b0, 2, "rd_10_after_mis");
`endif

        // WAIT_CYCLES=0 instance
        req(1, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 0, "w0_wr_0");
        req(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 0, "w0_rd_0");
        req(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 0, "w0_rd_0_again");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
